// File: rtl/fir_bank_serial.sv
// Serial-MAC FIR filter bank: NCH channels share one TAPS-deep delay line and
// run one MAC per channel per cycle, with rounded, saturated outputs.
module fir_bank_serial #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 16,
  parameter int TAPS   = 119,
  parameter int NCH    = 16,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 27,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int TAP_W = $clog2(TAPS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       filter_in,
  input  logic                    coef_we,
  input  logic [CH_W-1:0]         coef_ch,
  input  logic [TAP_W-1:0]        coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    coef_ready,
  output logic [NCH*OUT_W-1:0]    filter_out,
  output logic                    out_valid,
  output logic [NCH-1:0]          out_sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  // Post-round arithmetic is widened so neither the rounding add nor the clamp bounds overflow.
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;
  localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic signed [EXT_W-1:0] RND     = (EXT_W'(1) << SHIFT) >> 1;
  localparam logic [TAP_W-1:0]        LAST_T  = TAP_W'(TAPS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [TAP_W-1:0]          t;
  logic signed [DATA_W-1:0]  dl      [TAPS];
  logic signed [COEF_W-1:0]  coef    [NCH][TAPS];
  logic signed [ACC_W-1:0]   acc     [NCH];
  logic signed [PROD_W-1:0]  prod    [NCH];
  logic signed [ACC_W-1:0]   acc_sum [NCH];
  logic signed [EXT_W-1:0]   scaled  [NCH];
  logic [NCH*OUT_W-1:0]      res;
  logic [NCH-1:0]            sat;
  logic                      coef_hit;

  assign in_ready   = clk_enable && (state == IDLE);
  assign coef_ready = clk_enable && (state == IDLE);
  assign coef_hit   = coef_we && coef_ready && (32'(coef_ch) < NCH) && (32'(coef_addr) < TAPS);

  always_comb begin
    res = '0;
    sat = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      prod[c]    = PROD_W'(dl[t]) * PROD_W'(coef[c][t]);
      acc_sum[c] = acc[c] + ACC_W'(prod[c]);
      scaled[c]  = (EXT_W'(acc_sum[c]) + RND) >>> SHIFT;
      if (scaled[c] > OUT_MAX) begin
        res[c*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
        sat[c]                = 1'b1;
      end else if (scaled[c] < OUT_MIN) begin
        res[c*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
        sat[c]                = 1'b1;
      end else begin
        res[c*OUT_W +: OUT_W] = scaled[c][OUT_W-1:0];
      end
    end
  end

  // Coefficient memory deliberately has no reset so loaded filters survive it.
  always_ff @(posedge clock) begin
    if (coef_hit) begin
      coef[coef_ch][coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      t          <= '0;
      out_valid  <= 1'b0;
      out_sat    <= '0;
      filter_out <= '0;
      for (int unsigned i = 0; i < TAPS; i++) dl[i] <= '0;
      for (int unsigned c = 0; c < NCH; c++) acc[c] <= '0;
    end else if (clk_enable) begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dl[0] <= filter_in;
            for (int unsigned i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
            for (int unsigned c = 0; c < NCH; c++) acc[c] <= '0;
            t     <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          for (int unsigned c = 0; c < NCH; c++) acc[c] <= acc_sum[c];
          if (t == LAST_T) begin
            filter_out <= res;
            out_sat    <= sat;
            out_valid  <= 1'b1;
            t          <= '0;
            state      <= IDLE;
          end else begin
            t <= t + TAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_bank_serial.sv
// Bench for fir_bank_serial: two instances (unscaled wide output and
// SHIFT=2 / 8-bit output) share stimulus and are checked against a sum-of-products model.
module tb_fir_bank_serial;

  localparam int DATA_W = 10;
  localparam int COEF_W = 16;
  localparam int TAPS   = 4;
  localparam int NCH    = 3;
  localparam int OW_A   = 27;
  localparam int OW_B   = 8;
  localparam int SH_B   = 2;
  localparam int LIMIT  = 200;

  logic                clock, reset, clk_enable, in_valid, coef_we;
  logic [DATA_W-1:0]   filter_in;
  logic [1:0]          coef_ch;
  logic [1:0]          coef_addr;
  logic [COEF_W-1:0]   coef_data;
  logic                in_ready_a, coef_ready_a, out_valid_a;
  logic                in_ready_b, coef_ready_b, out_valid_b;
  logic [NCH*OW_A-1:0] filter_out_a;
  logic [NCH*OW_B-1:0] filter_out_b;
  logic [NCH-1:0]      out_sat_a, out_sat_b;

  fir_bank_serial #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .NCH(NCH),
                    .SHIFT(0), .OUT_W(OW_A)) u_dut_a (
    .clock(clock), .reset(reset), .clk_enable(clk_enable), .in_valid(in_valid),
    .in_ready(in_ready_a), .filter_in(filter_in), .coef_we(coef_we), .coef_ch(coef_ch),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready_a),
    .filter_out(filter_out_a), .out_valid(out_valid_a), .out_sat(out_sat_a));

  fir_bank_serial #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .NCH(NCH),
                    .SHIFT(SH_B), .OUT_W(OW_B)) u_dut_b (
    .clock(clock), .reset(reset), .clk_enable(clk_enable), .in_valid(in_valid),
    .in_ready(in_ready_b), .filter_in(filter_in), .coef_we(coef_we), .coef_ch(coef_ch),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready_b),
    .filter_out(filter_out_b), .out_valid(out_valid_b), .out_sat(out_sat_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  longint hist  [TAPS];
  longint mcoef [NCH][TAPS];
  longint exp_a [NCH];
  longint exp_b [NCH];
  bit     esat_a[NCH];
  bit     esat_b[NCH];
  longint seq[$];
  longint got_a0[$], got_a1[$], got_b0[$], gsat_b0[$];
  longint imp0[5] = '{5, 10, 15, 20, 0};
  longint imp1[5] = '{-5, 0, 0, 5, 0};

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] fo_a(input int c);
    return $signed(filter_out_a[c*OW_A +: OW_A]);
  endfunction

  function automatic logic signed [63:0] fo_b(input int c);
    return $signed(filter_out_b[c*OW_B +: OW_B]);
  endfunction

  // Reference: y = sum_k coef[c][k]*x[n-k], round half up, clamp to outw bits.
  function automatic longint model(input int c, input int shift, input int outw,
                                   output bit sat);
    longint s = 0;
    longint hi = (longint'(1) << (outw - 1)) - 1;
    longint lo = -(longint'(1) << (outw - 1));
    for (int k = 0; k < TAPS; k++) s += mcoef[c][k] * hist[k];
    if (shift > 0) s = (s + (longint'(1) << (shift - 1))) >>> shift;
    sat = 1'b0;
    if (s > hi) begin s = hi; sat = 1'b1; end
    else if (s < lo) begin s = lo; sat = 1'b1; end
    return s;
  endfunction

  function automatic void push_n(input longint v, input int n);
    for (int i = 0; i < n; i++) seq.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_coef(input int ch, input int addr, input longint data,
                            input bit exp_ready);
    coef_we   = 1'b1;
    coef_ch   = 2'(ch);
    coef_addr = 2'(addr);
    coef_data = 16'(data);
    #1;
    check("coef_ready", coef_ready_a, exp_ready);
    tick();
    coef_we = 1'b0;
    if (exp_ready && ch < NCH && addr < TAPS) mcoef[ch][addr] = data;
  endtask

  task automatic present(input longint x, input bit rnd_en);
    bit ok = 1'b0;
    int n = 0;
    in_valid  = 1'b1;
    filter_in = 10'(x);
    while (!ok && n < LIMIT) begin
      clk_enable = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      ok = (in_ready_a === 1'b1);
      tick();
      n++;
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL accept_wait observed=timeout(%0d) expected=accept", n);
    end
    if (ok) begin
      accept_cyc = cyc;
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      for (int c = 0; c < NCH; c++) begin
        exp_a[c] = model(c, 0, OW_A, esat_a[c]);
        exp_b[c] = model(c, SH_B, OW_B, esat_b[c]);
      end
      check("pulse_end", out_valid_a, 1'b0);
      check("busy_in_ready", in_ready_a, 1'b0);
    end
  endtask

  task automatic await_result(input bit rnd_en, input string tag, input int pre);
    int en = pre;
    int n = 0;
    bit seen = 1'b0;
    bit ce;
    while (!seen && n < LIMIT) begin
      clk_enable = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      ce = clk_enable;
      tick();
      n++;
      if (ce) en++;
      seen = (out_valid_a === 1'b1);
    end
    check({tag, "_latency"}, seen ? en : -1, TAPS);
    if (seen) begin
      check({tag, "_valid_b"}, out_valid_b, 1'b1);
      for (int c = 0; c < NCH; c++) begin
        check({tag, "_out_a"}, fo_a(c), exp_a[c]);
        check({tag, "_sat_a"}, out_sat_a[c], esat_a[c]);
        check({tag, "_out_b"}, fo_b(c), exp_b[c]);
        check({tag, "_sat_b"}, out_sat_b[c], esat_b[c]);
      end
      got_a0.push_back(fo_a(0));
      got_a1.push_back(fo_a(1));
      got_b0.push_back(fo_b(0));
      gsat_b0.push_back(longint'(out_sat_b[0]));
      if (rnd_en) begin
        clk_enable = 1'b0;
        #1;
        check({tag, "_gated_in_ready"}, in_ready_a, 1'b0);
        check({tag, "_gated_coef_ready"}, coef_ready_a, 1'b0);
        tick();
        check({tag, "_valid_held"}, out_valid_a, 1'b1);
        check({tag, "_out_held"}, fo_a(0), exp_a[0]);
        clk_enable = 1'b1;
      end
    end
  endtask

  task automatic stream(input bit rnd_en, input bit chk_int, input int gap,
                        input bit poke, input string tag);
    int prev = 0;
    got_a0.delete(); got_a1.delete(); got_b0.delete(); gsat_b0.delete();
    foreach (seq[i]) begin
      present(seq[i], rnd_en);
      if (chk_int && i > 0) check({tag, "_interval"}, accept_cyc - prev, TAPS + 1);
      prev = accept_cyc;
      if (poke && i == 0) begin
        write_coef(0, 0, 999, 1'b0);
        await_result(rnd_en, tag, 1);
      end else begin
        await_result(rnd_en, tag, 0);
      end
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_impulse(input string tag);
    check({tag, "_count"}, got_a0.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_a0.size()) begin
        check({tag, "_ch0"}, got_a0[i], imp0[i]);
        check({tag, "_ch1"}, got_a1[i], imp1[i]);
      end
    end
  endtask

  function automatic void impulse_seq();
    seq.delete();
    seq.push_back(5);
    push_n(0, 4);
  endfunction

  initial begin
    logic signed [COEF_W-1:0] rc;
    logic signed [DATA_W-1:0] rx;
    reset = 1'b1; clk_enable = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    filter_in = '0; coef_ch = '0; coef_addr = '0; coef_data = '0;
    foreach (hist[k]) hist[k] = 0;
    tick();
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_filter_out_a", filter_out_a, 0);
    check("rst_filter_out_b", filter_out_b, 0);
    check("rst_out_sat", out_sat_a, 0);
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_coef_ready", coef_ready_a, 1'b1);
    reset = 1'b0;
    tick();

    // Impulse with spaced accepts
    for (int k = 0; k < TAPS; k++) begin
      write_coef(0, k, k + 1, 1'b1);
      write_coef(1, k, (k == 0) ? -1 : (k == TAPS - 1) ? 1 : 0, 1'b1);
      write_coef(2, k, 3 - 2 * k, 1'b1);
    end
    impulse_seq();
    stream(1'b0, 1'b0, 3, 1'b0, "impulse");
    check_impulse("impulse");

    // Same impulse with clk_enable toggled at random
    stream(1'b1, 1'b0, 0, 1'b0, "gated");
    clk_enable = 1'b1;
    check_impulse("gated");

    // Dropped writes: out-of-range channel while idle, any channel while busy
    write_coef(3, 1, 777, 1'b1);
    stream(1'b0, 1'b1, 0, 1'b1, "busy_we");
    check_impulse("busy_we");

    // Reset mid-computation at t=2
    seq.delete();
    seq.push_back(3);
    stream(1'b0, 1'b0, 0, 1'b0, "pre_rst");
    present(7, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid_a, 1'b0);
    check("midrst_filter_out_a", filter_out_a, 0);
    check("midrst_filter_out_b", filter_out_b, 0);
    check("midrst_out_sat_b", out_sat_b, 0);
    check("midrst_in_ready", in_ready_a, 1'b1);
    in_valid = 1'b0;
    foreach (hist[k]) hist[k] = 0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < TAPS + 2; i++) begin
      tick();
      check("midrst_no_valid", out_valid_a, 1'b0);
    end
    impulse_seq();
    stream(1'b0, 1'b0, 0, 1'b0, "post_rst");
    check_impulse("post_rst");

    // Random coefficients and samples, in_valid held continuously
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < TAPS; k++) begin
        rc = COEF_W'($urandom);
        write_coef(c, k, longint'(rc), 1'b1);
      end
    seq.delete();
    for (int i = 0; i < 12; i++) begin
      rx = DATA_W'($urandom);
      seq.push_back(longint'(rx));
    end
    stream(1'b0, 1'b1, 0, 1'b0, "random");

    // Saturation at both rails on the 8-bit instance
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < TAPS; k++) write_coef(c, k, 32767, 1'b1);
    seq.delete();
    push_n(511, 4);
    push_n(-512, 4);
    stream(1'b0, 1'b1, 0, 1'b0, "sat");
    if (got_b0.size() == 8) begin
      check("sat_pos_value", got_b0[3], 127);
      check("sat_pos_flag", gsat_b0[3], 1);
      check("sat_neg_value", got_b0[7], -128);
      check("sat_neg_flag", gsat_b0[7], 1);
    end else begin
      check("sat_count", got_b0.size(), 8);
    end

    // Round half up with SHIFT=2 on the 8-bit instance
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < TAPS; k++) write_coef(c, k, (k == 0) ? 1 : 0, 1'b1);
    seq.delete();
    seq.push_back(6);
    seq.push_back(-6);
    seq.push_back(5);
    stream(1'b0, 1'b0, 1, 1'b0, "round");
    if (got_b0.size() == 3) begin
      check("round_6", got_b0[0], 2);
      check("round_m6", got_b0[1], -1);
      check("round_5", got_b0[2], 1);
      check("round_flag", gsat_b0[0], 0);
    end else begin
      check("round_count", got_b0.size(), 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
